// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flow-control unit for the 5-stage pipeline: produces stall/bubble
// controls for PC/FD/DE/EM, sequences multi-cycle execute ops, counts stalls and flushes.
module pipeline_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_use_rs1,
  input  logic             fd_use_rs2,
  input  logic [REG_W-1:0] de_rd,
  input  logic             de_is_load,
  input  logic             branch_taken,
  input  logic             mc_req,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_bubble,
  output logic             de_stall,
  output logic             de_bubble,
  output logic             em_stall,
  output logic             em_bubble,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = $clog2(MULDIV_LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_MULTI = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          load_use;
  logic          flush;

  assign load_use = de_is_load && (de_rd != '0) &&
                    ((fd_use_rs1 && (fd_rs1 == de_rd)) ||
                     (fd_use_rs2 && (fd_rs2 == de_rd)));

  always_comb begin
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_bubble = 1'b0;
    de_stall  = 1'b0;
    de_bubble = 1'b0;
    em_stall  = 1'b0;
    em_bubble = 1'b0;
    mc_done   = 1'b0;
    flush     = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rst) begin
      // Pipeline registers are cleared for as long as reset is held.
      fd_bubble = 1'b1;
      de_bubble = 1'b1;
      em_bubble = 1'b1;
    end else if (state == S_RUN) begin
      if (dmem_wait) begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_stall = 1'b1;
        em_stall = 1'b1;
      end else if (branch_taken) begin
        fd_bubble = 1'b1;
        de_bubble = 1'b1;
        flush     = 1'b1;
      end else if (mc_req) begin
        pc_stall  = 1'b1;
        fd_stall  = 1'b1;
        de_stall  = 1'b1;
        em_bubble = 1'b1;
        cnt_nxt   = CNT_LOAD;
        state_nxt = S_MULTI;
      end else if (load_use) begin
        pc_stall  = 1'b1;
        fd_stall  = 1'b1;
        de_bubble = 1'b1;
      end else if (imem_wait) begin
        pc_stall  = 1'b1;
        fd_bubble = 1'b1;
      end
    end else begin
      // The latency countdown keeps running while the memory stage is frozen.
      if (cnt != '0) cnt_nxt = cnt - 1'b1;
      if (dmem_wait) begin
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        de_stall = 1'b1;
        em_stall = 1'b1;
      end else if (cnt != '0) begin
        pc_stall  = 1'b1;
        fd_stall  = 1'b1;
        de_stall  = 1'b1;
        em_bubble = 1'b1;
      end else begin
        mc_done   = 1'b1;
        state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1))    flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic checked
// against a transaction-level reference; a narrow-counter instance exercises saturation.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int LAT   = 4;
  localparam int CNT_W = 16;
  localparam int SAT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [REG_W-1:0] fd_rs1 = '0, fd_rs2 = '0, de_rd = '0;
  logic fd_use_rs1 = 0, fd_use_rs2 = 0, de_is_load = 0;
  logic branch_taken = 0, mc_req = 0, imem_wait = 0, dmem_wait = 0;

  logic pc_stall, fd_stall, fd_bubble, de_stall, de_bubble, em_stall, em_bubble, mc_done;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic s_pc, s_fd, s_fdb, s_de, s_deb, s_em, s_emb, s_done;
  logic [SAT_W-1:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MULDIV_LAT(LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_use_rs1(fd_use_rs1), .fd_use_rs2(fd_use_rs2), .de_rd(de_rd),
    .de_is_load(de_is_load), .branch_taken(branch_taken), .mc_req(mc_req),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_bubble(fd_bubble),
    .de_stall(de_stall), .de_bubble(de_bubble), .em_stall(em_stall),
    .em_bubble(em_bubble), .mc_done(mc_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MULDIV_LAT(LAT), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_use_rs1(fd_use_rs1), .fd_use_rs2(fd_use_rs2), .de_rd(de_rd),
    .de_is_load(de_is_load), .branch_taken(branch_taken), .mc_req(mc_req),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .pc_stall(s_pc), .fd_stall(s_fd), .fd_bubble(s_fdb),
    .de_stall(s_de), .de_bubble(s_deb), .em_stall(s_em),
    .em_bubble(s_emb), .mc_done(s_done),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: an outstanding multi-cycle op is tracked as "busy" with a number
  // of remaining front-end stall cycles; counters are unbounded event tallies.
  bit m_busy;
  int m_left;
  int n_stall, n_flush;
  logic [7:0] obs;

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [7:0] pack_main();
    return {pc_stall, fd_stall, fd_bubble, de_stall, de_bubble, em_stall, em_bubble, mc_done};
  endfunction

  function automatic logic [7:0] pack_sat();
    return {s_pc, s_fd, s_fdb, s_de, s_deb, s_em, s_emb, s_done};
  endfunction

  function automatic logic [7:0] model_out();
    logic pc, fd, fdb, de, deb, em, emb, done, lu;
    {pc, fd, fdb, de, deb, em, emb, done} = '0;
    lu = de_is_load && de_rd != 0 &&
         ((fd_use_rs1 && fd_rs1 == de_rd) || (fd_use_rs2 && fd_rs2 == de_rd));
    if (m_busy) begin
      if (dmem_wait)       {pc, fd, de, em} = 4'hF;
      else if (m_left > 0) {pc, fd, de, emb} = 4'hF;
      else                 done = 1;
    end else if (dmem_wait)    {pc, fd, de, em} = 4'hF;
    else if (branch_taken)     {fdb, deb} = 2'b11;
    else if (mc_req)           {pc, fd, de, emb} = 4'hF;
    else if (lu)               {pc, fd, deb} = 3'b111;
    else if (imem_wait)        {pc, fdb} = 2'b11;
    return {pc, fd, fdb, de, deb, em, emb, done};
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(sat(n_stall, CNT_W)));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(sat(n_flush, CNT_W)));
    chk({tag, ".sat_stall"}, 32'(s_stall_cnt), 32'(sat(n_stall, SAT_W)));
    chk({tag, ".sat_flush"}, 32'(s_flush_cnt), 32'(sat(n_flush, SAT_W)));
  endtask

  // One clock of stimulus: drive at negedge, check settled outputs, advance model.
  task automatic step(input string tag, input logic dw, input logic bt, input logic mc,
                      input logic iw, input logic ld, input int rd, input int r1,
                      input int r2, input logic u1, input logic u2);
    logic [7:0] e;
    @(negedge clk);
    dmem_wait = dw; branch_taken = bt; mc_req = mc; imem_wait = iw;
    de_is_load = ld; de_rd = REG_W'(rd); fd_rs1 = REG_W'(r1); fd_rs2 = REG_W'(r2);
    fd_use_rs1 = u1; fd_use_rs2 = u2;
    #1;
    e = model_out();
    obs = pack_main();
    chk({tag, ".ctl"}, 32'(obs), 32'(e));
    chk({tag, ".sat_ctl"}, 32'(pack_sat()), 32'(e));
    check_counters(tag);
    if (e[7]) n_stall++;
    if (m_busy) begin
      if (!dw && m_left == 0) m_busy = 0;
      if (m_left > 0) m_left--;
    end else if (!dw) begin
      if (bt) n_flush++;
      else if (mc) begin m_busy = 1; m_left = LAT - 1; end
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    {dmem_wait, branch_taken, mc_req, imem_wait, de_is_load, fd_use_rs1, fd_use_rs2} = '0;
    rst = 1'b1;
    #1;
    m_busy = 0; m_left = 0; n_stall = 0; n_flush = 0;
    chk({tag, ".rst_ctl"}, 32'(pack_main()), 32'h0000_002A);
    check_counters(tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, ".post_rst"}, 32'(pack_main()), 32'h0);
  endtask

  int dones;

  initial begin
    m_busy = 0; m_left = 0; n_stall = 0; n_flush = 0;
    do_reset("init");
    idle("idle");

    step("lu", 0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
    chk("lu.direct", 32'(obs), 32'h0000_00C8);
    step("lu_rd0", 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    chk("lu_rd0.direct", 32'(obs), 32'h0);
    step("lu_rs2", 0, 0, 0, 0, 1, 7, 3, 7, 0, 1);
    step("imem", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    do_reset("mc_rst");
    dones = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      step("mc_hold", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      if (obs[0]) dones++;
      if (i < LAT) chk("mc_hold.stall", 32'({obs[7], obs[1]}), 32'h3);
    end
    chk("mc_hold.done", 32'(dones), 32'(1));
    chk("mc_hold.last_done", 32'(obs[0]), 32'(1));
    chk("mc_hold.stall_cnt", 32'(stall_cnt), 32'(LAT));
    idle("mc_after");

    dones = 0;
    step("mcd0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("mcd1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("mcd_dw", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("mcd_dw.em_stall", 32'(obs[2]), 32'(1));
    end
    for (int i = 0; i < 3; i++) begin
      step("mcd_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (obs[0]) dones++;
    end
    chk("mcd.done_once", 32'(dones), 32'(1));

    step("br_all", 0, 1, 1, 1, 1, 4, 4, 4, 1, 1);
    chk("br_all.direct", 32'(obs), 32'h0000_0028);
    step("br_dw", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_dw.direct", 32'(obs), 32'h0000_00D4);
    idle("br_idle");

    step("mr0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("mr1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("mid_multi");
    idle("mid_multi_idle");

    for (int i = 0; i < 12; i++) step("sat_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("sat_br", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat.stall_top", 32'(s_stall_cnt), 32'h7);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      step("rnd", $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
